// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl: sequencer/configurator for a counter/comparator PWM datapath.
//
// Divides clk_i into a one-cycle PWM count enable (tick_o), mirrors the period
// counter (cont_o), holds a button/software target duty (target_o), and moves
// the comparator reference (ref_o) toward the target only at period boundaries,
// so no glitch pulses reach the PWM output.
//
// Build option: define PWM_DUTY_RAMP_EN to slew ref_o by one LSB per period.
// Without it, ref_o loads target_o at the first boundary.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset        asynchronous active-high reset
//   en_i         run enable; low freezes prescaler, period counter and ref_o
//   up_i         pulse: target +1 (saturating)
//   down_i       pulse: target -1 (saturating)
//   set_i        pulse: load target from set_val_i (highest priority)
//   set_val_i    direct target value
//   tick_o       one-cycle count enable for the PWM counter
//   cont_o       period counter mirror
//   ref_o        duty reference to the comparator
//   target_o     current target duty
//   period_end_o high on the tick that wraps cont_o
//   busy_o       high while the reference is being moved (RAMP state)
module pwm_duty_ctrl #(
    parameter int unsigned DIV       = 4,
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned INIT_DUTY = 0
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             down_i,
    input  logic             set_i,
    input  logic [WIDTH-1:0] set_val_i,
    output logic             tick_o,
    output logic [WIDTH-1:0] cont_o,
    output logic [WIDTH-1:0] ref_o,
    output logic [WIDTH-1:0] target_o,
    output logic             period_end_o,
    output logic             busy_o
);

    localparam int unsigned    PW         = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] CONT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT_DUTY);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RAMP = 1'b1;

    logic [PW-1:0]    presc_q, presc_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] cont_q, cont_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] ref_step;
    logic             tick;
    logic             period_end;

    // A pending tick is held while en_i is low and only presented when running,
    // so pausing never loses or duplicates a count.
    assign tick       = tick_q & en_i;
    assign period_end = tick & (cont_q == CONT_MAX);

    always_comb begin
        presc_d = presc_q;
        tick_d  = tick_q;
        if (en_i) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
                tick_d  = 1'b0;
            end
        end
    end

    always_comb begin
        cont_d = cont_q;
        if (tick) begin
            cont_d = cont_q + 1'b1;
        end
    end

    always_comb begin
        target_d = target_q;
        if (set_i) begin
            target_d = set_val_i;
        end else if (up_i && down_i) begin
            target_d = target_q;
        end else if (up_i) begin
            if (target_q != CONT_MAX) target_d = target_q + 1'b1;
        end else if (down_i) begin
            if (target_q != '0) target_d = target_q - 1'b1;
        end
    end

    // Next reference value applied at a boundary; direction re-evaluated each time.
    always_comb begin
`ifdef PWM_DUTY_RAMP_EN
        if (ref_q < target_q) begin
            ref_step = ref_q + 1'b1;
        end else if (ref_q > target_q) begin
            ref_step = ref_q - 1'b1;
        end else begin
            ref_step = ref_q;
        end
`else
        ref_step = target_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        case (state_q)
            ST_IDLE: begin
                if (target_q != ref_q) state_d = ST_RAMP;
            end
            ST_RAMP: begin
                if (period_end) begin
                    ref_d = ref_step;
                    if (ref_step == target_q) state_d = ST_IDLE;
                end else if (target_q == ref_q) begin
                    // Target withdrawn before any boundary: nothing to do.
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            presc_q  <= '0;
            tick_q   <= 1'b0;
            cont_q   <= '0;
            target_q <= INIT_VAL;
            ref_q    <= INIT_VAL;
            state_q  <= ST_IDLE;
        end else begin
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            cont_q   <= cont_d;
            target_q <= target_d;
            ref_q    <= ref_d;
            state_q  <= state_d;
        end
    end

    assign tick_o       = tick;
    assign cont_o       = cont_q;
    assign ref_o        = ref_q;
    assign target_o     = target_q;
    assign period_end_o = period_end;
    assign busy_o       = (state_q == ST_RAMP);

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Bench for pwm_duty_ctrl: a cycle model built from the behavioural rules is
// compared against every output on each falling edge, and directed vectors
// with hand-computed values pin the model. Inputs change 2 ns after rising edges.
module tb_pwm_duty_ctrl;

    localparam int DIV  = 4;
    localparam int W    = 4;
    localparam int INIT = 5;
    localparam int MAX  = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en_i = 1'b0;
    logic         up_i = 1'b0;
    logic         down_i = 1'b0;
    logic         set_i = 1'b0;
    logic [W-1:0] set_val_i = '0;
    logic         tick_o;
    logic [W-1:0] cont_o;
    logic [W-1:0] ref_o;
    logic [W-1:0] target_o;
    logic         period_end_o;
    logic         busy_o;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    int m_k      = 0;     // enabled clock edges since reset
    int m_cont   = 0;
    int m_target = INIT;
    int m_ref    = INIT;
    bit m_busy   = 1'b0;

    pwm_duty_ctrl #(
        .DIV       (DIV),
        .WIDTH     (W),
        .INIT_DUTY (INIT)
    ) dut (
        .clk_i        (clk),
        .reset        (reset),
        .en_i         (en_i),
        .up_i         (up_i),
        .down_i       (down_i),
        .set_i        (set_i),
        .set_val_i    (set_val_i),
        .tick_o       (tick_o),
        .cont_o       (cont_o),
        .ref_o        (ref_o),
        .target_o     (target_o),
        .period_end_o (period_end_o),
        .busy_o       (busy_o)
    );

    initial forever #5 clk = ~clk;

    // A tick is due after every DIV-th enabled edge and lasts until consumed.
    function automatic bit exp_tick(input bit en, input int k);
        return en && (k > 0) && (k % DIV == 0);
    endfunction

    function automatic int step_ref(input int r, input int tgt);
`ifdef PWM_DUTY_RAMP_EN
        if (tgt > r) return r + 1;
        if (tgt < r) return r - 1;
        return r;
`else
        return tgt;
`endif
    endfunction

    function automatic int next_target(input int t, input bit s, input int v,
                                       input bit up, input bit dn);
        if (s) return v;
        if (up && dn) return t;
        if (up) return (t == MAX) ? MAX : t + 1;
        if (dn) return (t == 0) ? 0 : t - 1;
        return t;
    endfunction

    initial begin
        bit t;
        bit pe;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_k = 0; m_cont = 0; m_target = INIT; m_ref = INIT; m_busy = 1'b0;
            end else begin
                t  = exp_tick(en_i, m_k);
                pe = t && (m_cont == MAX);
                if (m_busy) begin
                    if (pe) begin
                        m_ref  = step_ref(m_ref, m_target);
                        m_busy = (m_ref != m_target);
                    end else if (m_target == m_ref) begin
                        m_busy = 1'b0;
                    end
                end else begin
                    m_busy = (m_target != m_ref);
                end
                m_target = next_target(m_target, set_i, int'(set_val_i), up_i, down_i);
                if (t) m_cont = (m_cont + 1) % (MAX + 1);
                if (en_i) m_k++;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        bit et;
        bit ep;
        forever begin
            @(negedge clk);
            et = exp_tick(en_i, m_k);
            ep = et && (m_cont == MAX);
            n_vec++;
            if (tick_o !== et || period_end_o !== ep || int'(cont_o) != m_cont ||
                int'(ref_o) != m_ref || int'(target_o) != m_target || busy_o !== m_busy) begin
                n_err++;
                $display("FAIL cycle t=%0t: got tick=%b pe=%b cont=%0d ref=%0d tgt=%0d busy=%b, want tick=%b pe=%b cont=%0d ref=%0d tgt=%0d busy=%b",
                         $time, tick_o, period_end_o, cont_o, ref_o, target_o, busy_o,
                         et, ep, m_cont, m_ref, m_target, m_busy);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_set(input int v);
        set_val_i = W'(v);
        set_i = 1'b1;
        cycles(1);
        set_i = 1'b0;
    endtask

    // Advance until just past the next period boundary.
    task automatic wait_pe(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (period_end_o) begin
                seen = 1'b1;
                cycles(1);
                break;
            end
            cycles(1);
        end
        if (!seen) check({name, " boundary timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy_o) begin
                done = 1'b1;
                break;
            end
            cycles(1);
        end
        if (!done) check({name, " idle timeout"}, 0, 1);
    endtask

    initial begin
        int saved_ref;
        int saved_cont;
        int nb;

        cycles(3);
        reset = 1'b0;
        en_i = 1'b1;
        pulse_set(9);
        cycles(5);
        // Asynchronous reset mid-cycle and mid-count.
        #1 reset = 1'b1;
        #1;
        check("rst ref", int'(ref_o), 5);
        check("rst target", int'(target_o), 5);
        check("rst cont", int'(cont_o), 0);
        check("rst busy", int'(busy_o), 0);
        check("rst tick", int'(tick_o), 0);
        check("rst pe", int'(period_end_o), 0);
        en_i = 1'b0;
        cycles(1);
        reset = 1'b0;
        cycles(1);

        // Prescaler and period counter.
        en_i = 1'b1;
        cycles(4);
        check("first tick", int'(tick_o), 1);
        check("cont at first tick", int'(cont_o), 0);
        cycles(1);
        check("tick one cycle", int'(tick_o), 0);
        check("cont after first tick", int'(cont_o), 1);
        cycles(59);
        check("tick 16", int'(tick_o), 1);
        check("cont 15", int'(cont_o), 15);
        check("period_end at wrap", int'(period_end_o), 1);
        cycles(1);
        check("cont wrapped", int'(cont_o), 0);
        check("period_end low", int'(period_end_o), 0);

        // Target saturation and priority.
        pulse_set(0);
        check("target set 0", int'(target_o), 0);
        up_i = 1'b1;
        cycles(20);
        up_i = 1'b0;
        check("target up sat", int'(target_o), 15);
        up_i = 1'b1; down_i = 1'b1;
        cycles(1);
        up_i = 1'b0; down_i = 1'b0;
        check("target up+down", int'(target_o), 15);
        pulse_set(0);
        down_i = 1'b1;
        cycles(1);
        down_i = 1'b0;
        check("target down sat", int'(target_o), 0);
        cycles(2);
        wait_idle("settle to 0");
        check("ref settled 0", int'(ref_o), 0);

        // Ramp 0 -> 3.
        pulse_set(3);
        cycles(1);
        check("busy after set 3", int'(busy_o), 1);
`ifdef PWM_DUTY_RAMP_EN
        for (int i = 1; i <= 3; i++) begin
            wait_pe("ramp up");
            check("ramp ref step", int'(ref_o), i);
            check("ramp busy", int'(busy_o), (i < 3) ? 1 : 0);
        end
`else
        wait_pe("jump");
        check("jump ref", int'(ref_o), 3);
        check("jump busy", int'(busy_o), 0);
`endif

        // Redirect during ramp, with a pause in the middle.
        pulse_set(2);
        cycles(2);
        wait_idle("settle to 2");
        check("ref settled 2", int'(ref_o), 2);
        pulse_set(10);
`ifdef PWM_DUTY_RAMP_EN
        nb = 0;
        while (int'(ref_o) != 5 && nb < 12) begin
            wait_pe("ramp to 5");
            nb++;
        end
        check("boundaries 2->5", nb, 3);
`else
        cycles(2);
`endif
        saved_ref  = m_ref;
        saved_cont = m_cont;
        en_i = 1'b0;
        up_i = 1'b1;
        cycles(1);
        up_i = 1'b0;
        cycles(99);
        check("freeze ref", int'(ref_o), saved_ref);
        check("freeze cont", int'(cont_o), saved_cont);
        check("freeze busy", int'(busy_o), 1);
        check("freeze tick", int'(tick_o), 0);
        check("target moves while frozen", int'(target_o), 11);
        en_i = 1'b1;
        pulse_set(1);
        wait_pe("redirect");
`ifdef PWM_DUTY_RAMP_EN
        check("reverse first step", int'(ref_o), 4);
        wait_idle("ramp down");
`endif
        check("ref reached 1", int'(ref_o), 1);
        check("idle at 1", int'(busy_o), 0);

        // Target set back before any boundary: no reference change.
        en_i = 1'b0;
        pulse_set(2);
        pulse_set(1);
        check("setback busy", int'(busy_o), 1);
        cycles(1);
        check("setback idle", int'(busy_o), 0);
        check("setback ref", int'(ref_o), 1);
        en_i = 1'b1;
        cycles(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
